// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// The request fields stay stable from issue until the memory returns dmem_ack.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives data-memory loads/stores through an IDLE/WAIT/DONE
// handshake, stalls the pipeline while an access is outstanding, aligns and extends
// load data, and resolves branch/jump redirects.
// Optional feature: define MEM_TIMEOUT_EN to add the timeout_err output and a WAIT
// watchdog that abandons an access after 255 cycles without dmem_ack.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mr,
    input  logic        mw,
    input  logic        br,
    input  logic        j,
    input  logic        jr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] adder_result,
    input  logic [31:0] rd2,
    input  logic        zero,
    input  logic        neg,
    input  logic        carry,
    input  logic        overflow,
    mem_access_unit_if.master dmem,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        misalign
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Access size codes: 0 = undefined funct3, 1 = byte, 2 = halfword, 3 = word
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 2'd1;
            3'b001, 3'b101: return 2'd2;
            3'b010:         return 2'd3;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd2:    return ~lane[0];
            2'd3:    return (lane == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd1:    return 4'b0001 << lane;
            2'd2:    return lane[1] ? 4'b1100 : 4'b0011;
            2'd3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Narrow stores replicate the datum across every lane so the byte enables alone pick the target
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd1:    return {4{d[7:0]}};
            2'd2:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [31:0]        sh;
        logic signed [31:0] sx;
        sh = rd >> {lane, 3'b000};
        case (f3)
            3'b000:  begin sx = $signed(sh[7:0]);  return sx; end
            3'b001:  begin sx = $signed(sh[15:0]); return sx; end
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            3'b010:  return sh;  // word accesses are always lane 0
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3, input logic z, input logic n,
                                         input logic c, input logic v);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return n ^ v;
            3'b101:  return ~(n ^ v);
            3'b110:  return ~c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    state_t      state, state_n;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_p1;
    logic [1:0]  lane_p1;
    logic [1:0]  size;
    logic        access, aligned, issue, misalign_set, timeout_hit, finish;

    assign access  = mr | mw;
    assign size    = access_size(funct3);
    assign aligned = is_aligned(size, alu_result[1:0]);
    assign finish  = (state == WAIT) && (dmem.dmem_ack || timeout_hit);

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; DONE always returns to IDLE so the held instruction is not reissued
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (access && aligned) state_n = WAIT;
            WAIT:    if (dmem.dmem_ack || timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: issue strobe, misalignment detection and pipeline stall
    always_comb begin
        issue        = 1'b0;
        misalign_set = 1'b0;
        stall        = 1'b0;
        case (state)
            IDLE: begin
                issue        = access & aligned;
                misalign_set = access & ~aligned;
                stall        = access & aligned;
            end
            WAIT:    stall = 1'b1;
            default: ;
        endcase
    end

    // Memory request registers: loaded at issue, held through WAIT, released on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (issue) begin
            req_q   <= 1'b1;
            we_q    <= mw;
            addr_q  <= {alu_result[31:2], 2'b00};
            wdata_q <= store_data(size, rd2);
            be_q    <= byte_enables(size, alu_result[1:0]);
        end else if (finish) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
        end
    end

    // Load formatting context captured with the request
    always_ff @(posedge clk) begin
        if (issue) begin
            f3_p1   <= funct3;
            lane_p1 <= alu_result[1:0];
        end
    end

    // Load result: formatted on ack for loads only; cleared when the access times out
    always_ff @(posedge clk) begin
        if (reset) begin
            load_data <= 32'd0;
        end else if (state == WAIT) begin
            if (dmem.dmem_ack) begin
                if (!we_q) load_data <= load_extract(f3_p1, lane_p1, dmem.dmem_rdata);
            end else if (timeout_hit) begin
                load_data <= 32'd0;
            end
        end
    end

    // Misalignment pulse, one cycle after the offending instruction is seen
    always_ff @(posedge clk) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= misalign_set;
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // The 255th consecutive WAIT cycle without ack ends the access
    assign timeout_hit = (state == WAIT) && !dmem.dmem_ack && (wait_cnt == 8'd254);

    // WAIT-cycle watchdog and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else if (state != WAIT) begin
            wait_cnt    <= 8'd0;
        end else begin
            wait_cnt    <= wait_cnt + 8'd1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Redirects are suppressed while the pipeline is frozen
    assign pc_src    = ((br & branch_cond(funct3, zero, neg, carry, overflow)) | j | jr) & ~stall;
    assign pc_target = jr ? {alu_result[31:1], 1'b0} : adder_result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues directed and random
// instructions and pushes expected bus/result/redirect items; a memory responder
// acks after a per-access delay; a monitor pops and compares as the DUT responds.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr, mw, br, j, jr;
    logic [2:0]  funct3;
    logic [31:0] alu_result, adder_result, rd2;
    logic        zero, neg, carry, overflow;
    logic [31:0] load_data;
    logic        stall, pc_src, misalign;
    logic [31:0] pc_target;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_err;
`endif

    mem_access_unit_if dmem();

    mem_access_unit dut (
        .clk(clk), .reset(reset), .mr(mr), .mw(mw), .br(br), .j(j), .jr(jr),
        .funct3(funct3), .alu_result(alu_result), .adder_result(adder_result), .rd2(rd2),
        .zero(zero), .neg(neg), .carry(carry), .overflow(overflow), .dmem(dmem),
        .load_data(load_data), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .misalign(misalign)
`ifdef MEM_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;    // 0 = memory request, 1 = misalignment
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic [3:0]  be;
        logic        we;
        logic        chk_be;
        logic        chk_wd;
    } exp_t;
    typedef struct { int delay; logic [31:0] rdata; } resp_t;
    typedef struct { logic src; logic [31:0] tgt; } br_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];
    br_t   br_q[$];
    int    stall_q[$];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_ld = 32'd0;
    logic        mon_en = 1'b0;
    logic        resp_en = 1'b0;
    logic        br_chk = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] force_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Hold the current instruction until the pipeline advances (stall low before an edge)
    task automatic run_instr();
        int   n = 0;
        logic s;
        do begin
            #1 s = stall;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (s && n < 1000);
        if (s) fail_evt("retire_timeout");
    endtask

    task automatic do_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int delay, input logic [31:0] rdata);
        exp_t        e;
        resp_t       r;
        int          sz, lane, slen;
        logic [31:0] w;
        lane = int'(addr[1:0]);
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        sz = 0;
        endcase
        e = '{kind: 0, addr: 0, wdata: 0, ld: 0, be: 0, we: 0, chk_be: 0, chk_wd: 0};
        if ((sz == 2 && lane % 2 != 0) || (sz == 4 && lane != 0)) begin
            e.kind = 1;
            e.ld   = model_ld;
            exp_q.push_back(e);
        end else begin
            e.addr   = addr & 32'hFFFF_FFFC;
            e.we     = st;
            e.chk_be = (sz != 0);
            e.chk_wd = st;
            e.be     = (sz == 1) ? 4'(1 << lane) : (sz == 2) ? 4'(3 << lane) : 4'hF;
            e.wdata  = (sz == 1) ? (data & 32'hFF) * 32'h0101_0101 :
                       (sz == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
            slen = delay + 2;
            if (!st) begin
                w = rdata >> (8 * lane);
                case (f3)
                    3'b000:  model_ld = ((w & 32'hFF) >= 32'h80) ? (w & 32'hFF) - 32'd256 : (w & 32'hFF);
                    3'b001:  model_ld = ((w & 32'hFFFF) >= 32'h8000) ? (w & 32'hFFFF) - 32'd65536 : (w & 32'hFFFF);
                    3'b100:  model_ld = w & 32'hFF;
                    3'b101:  model_ld = w & 32'hFFFF;
                    3'b010:  model_ld = rdata;
                    default: model_ld = 32'd0;
                endcase
            end
`ifdef MEM_TIMEOUT_EN
            if (delay >= 255) begin
                slen = 256;
                if (!st) model_ld = 32'd0;
            end
`endif
            e.ld = model_ld;
            r.delay = delay;
            r.rdata = rdata;
            exp_q.push_back(e);
            resp_q.push_back(r);
            stall_q.push_back(slen);
        end
        mr = !st; mw = st; funct3 = f3; alu_result = addr; rd2 = data;
        br = 0; jr = 0; j = 1'($urandom % 2); adder_result = $urandom;
        run_instr();
        mr = 0; mw = 0; j = 0;
    endtask

    task automatic do_branch(input logic b, input logic jj, input logic jjr, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] add,
                             input logic z, input logic n, input logic c, input logic v,
                             input logic exp_src, input logic [31:0] exp_tgt);
        br_t x;
        x.src = exp_src;
        x.tgt = exp_tgt;
        br_q.push_back(x);
        mr = 0; mw = 0; br = b; j = jj; jr = jjr; funct3 = f3;
        alu_result = alu; adder_result = add; zero = z; neg = n; carry = c; overflow = v;
        br_chk = 1;
        run_instr();
        br_chk = 0; br = 0; j = 0; jr = 0;
    endtask

    // Random branch/jump with flags derived from a real compare of two operands
    task automatic rand_branch();
        logic [31:0] a, b, diff, alu, add;
        logic [2:0]  f3;
        logic        taken;
        int          k;
        a = $urandom;
        b = ($urandom % 4 == 0) ? a : $urandom;
        diff = a - b;
        f3 = 3'($urandom % 8);
        alu = $urandom;
        add = $urandom;
        k = $urandom % 4;
        case (f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a < b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
        if (k < 2)
            do_branch(1, 0, 0, f3, alu, add, diff == 0, diff[31], a >= b,
                      (a[31] != b[31]) && (diff[31] != a[31]), taken, add);
        else if (k == 2)
            do_branch(0, 1, 0, f3, alu, add, diff == 0, diff[31], a >= b, 1'b0, 1'b1, add);
        else
            do_branch(0, 0, 1, f3, alu, add, diff == 0, diff[31], a >= b, 1'b0, 1'b1, alu & 32'hFFFF_FFFE);
    endtask

    // Memory responder: acks the delay-th WAIT cycle, throws spurious acks when idle
    initial begin
        int    cnt = 0;
        logic  active = 1'b0;
        resp_t cur;
        cur.delay = 0;
        cur.rdata = 0;
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                dmem.dmem_ack = force_ack;
                dmem.dmem_rdata = force_rdata;
                active = 1'b0;
            end else if (!dmem.dmem_req) begin
                active = 1'b0;
                dmem.dmem_ack = ($urandom % 3 == 0);
                dmem.dmem_rdata = $urandom;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (resp_q.size() > 0) cur = resp_q.pop_front();
                    else begin cur.delay = 0; cur.rdata = 32'd0; end
                end
                if (cnt == cur.delay) begin
                    dmem.dmem_ack = 1'b1;
                    dmem.dmem_rdata = cur.rdata;
                end else begin
                    dmem.dmem_ack = 1'b0;
                    dmem.dmem_rdata = $urandom;
                end
                cnt++;
            end
        end
    end

    // Monitor: pops expected items as the DUT raises requests, pulses, stalls and redirects
    initial begin
        logic prev_req = 1'b0, prev_stall = 1'b0, pend = 1'b0;
        int   scnt = 0;
        exp_t cur, e;
        br_t  x;
        cur = '{kind: 0, addr: 0, wdata: 0, ld: 0, be: 0, we: 0, chk_be: 0, chk_wd: 0};
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (pend) begin
                    chk("load_data", load_data, cur.ld);
                    pend = 1'b0;
                end
                if (misalign) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 1) fail_evt("unexpected_misalign");
                    else begin
                        e = exp_q.pop_front();
                        chk("misalign_load_data", load_data, e.ld);
                        chk("misalign_req", 32'(dmem.dmem_req), 32'd0);
                    end
                end
                if (dmem.dmem_req && !prev_req) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 0) fail_evt("unexpected_req");
                    else begin
                        cur = exp_q.pop_front();
                        chk("dmem_addr", dmem.dmem_addr, cur.addr);
                        chk("dmem_we", 32'(dmem.dmem_we), 32'(cur.we));
                        if (cur.chk_be) chk("dmem_be", 32'(dmem.dmem_be), 32'(cur.be));
                        if (cur.chk_wd) chk("dmem_wdata", dmem.dmem_wdata, cur.wdata);
                    end
                end else if (dmem.dmem_req && prev_req) begin
                    chk("dmem_addr_hold", dmem.dmem_addr, cur.addr);
                end
                if (dmem.dmem_req && dmem.dmem_ack) pend = 1'b1;
                if (stall) begin
                    scnt++;
                    chk("pc_src_stalled", 32'(pc_src), 32'd0);
                end else if (prev_stall) begin
                    if (stall_q.size() == 0) fail_evt("unexpected_stall");
                    else chk("stall_cycles", 32'(scnt), 32'(stall_q.pop_front()));
                    scnt = 0;
                end
                if (br_chk) begin
                    if (br_q.size() == 0) fail_evt("unexpected_branch");
                    else begin
                        x = br_q.pop_front();
                        chk("pc_src", 32'(pc_src), 32'(x.src));
                        chk("pc_target", pc_target, x.tgt);
                    end
                end
            end
            prev_req = dmem.dmem_req;
            prev_stall = stall;
        end
    end

    // Driver
    initial begin
        logic [2:0] f3;
        logic [31:0] a;
        int k;
        reset = 1; mr = 0; mw = 0; br = 0; j = 0; jr = 0; funct3 = 0;
        alu_result = 0; adder_result = 0; rd2 = 0; zero = 0; neg = 0; carry = 0; overflow = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 32'(dmem.dmem_req), 32'd0);
        chk("rst_we", 32'(dmem.dmem_we), 32'd0);
        chk("rst_be", 32'(dmem.dmem_be), 32'd0);
        chk("rst_addr", dmem.dmem_addr, 32'd0);
        chk("rst_wdata", dmem.dmem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
        @(negedge clk);
        reset = 0;
        mon_en = 1;
        resp_en = 1;
        @(negedge clk);

        // Directed cases
        do_mem(0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
        do_mem(0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
        do_mem(0, 3'b100, 32'h0000_0103, 32'h0, 2, 32'h8012_3456);
        do_mem(1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0);
        do_mem(1, 3'b010, 32'h0000_0101, 32'h5555_AAAA, 0, 32'h0);
        do_mem(0, 3'b001, 32'h0000_0203, 32'h0, 0, 32'h0);
        do_mem(0, 3'b101, 32'h0000_0202, 32'h0, 3, 32'hF00D_8001);
        do_mem(0, 3'b110, 32'h0000_0300, 32'h0, 0, 32'hFFFF_FFFF);
        do_mem(1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 1, 32'h0);
        do_branch(1, 0, 0, 3'b100, 32'h0, 32'h40, 0, 1, 0, 0, 1'b1, 32'h40);
        do_branch(0, 0, 1, 3'b000, 32'h55, 32'h40, 0, 0, 0, 0, 1'b1, 32'h54);
        do_branch(1, 0, 0, 3'b010, 32'h0, 32'h80, 1, 1, 1, 1, 1'b0, 32'h80);
        do_branch(1, 0, 0, 3'b011, 32'h0, 32'h84, 0, 0, 0, 0, 1'b0, 32'h84);

        // Randomized instruction stream
        for (int i = 0; i < 160; i++) begin
            k = $urandom % 10;
            a = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            if (k < 4) begin
                if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
                else begin
                    case ($urandom % 5)
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                do_mem(0, f3, a, $urandom, $urandom % 5, $urandom);
            end else if (k < 7) begin
                do_mem(1, 3'($urandom % 3), a, $urandom, $urandom % 5, $urandom);
            end else begin
                rand_branch();
            end
        end

`ifdef MEM_TIMEOUT_EN
        do_mem(0, 3'b010, 32'h0000_0400, 32'h0, 100000, 32'h1111_1111);
        #1;
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        chk("timeout_load_data", load_data, 32'd0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("stall_q_drained", 32'(stall_q.size()), 32'd0);
        chk("br_q_drained", 32'(br_q.size()), 32'd0);

        // Reset in the middle of WAIT, then a late ack that must be ignored
        mon_en = 0;
        resp_en = 0;
        force_ack = 0;
        force_rdata = 32'h0;
        mr = 1; mw = 0; funct3 = 3'b010; alu_result = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midwait_req", 32'(dmem.dmem_req), 32'd1);
        chk("midwait_stall", 32'(stall), 32'd1);
        reset = 1;
        mr = 0;
        @(negedge clk);
        #1;
        chk("abandon_req", 32'(dmem.dmem_req), 32'd0);
        chk("abandon_stall", 32'(stall), 32'd0);
        chk("abandon_load_data", load_data, 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
`endif
        reset = 0;
        force_ack = 1;
        force_rdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("late_ack_load_data", load_data, 32'd0);
        chk("late_ack_req", 32'(dmem.dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        force_ack = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single rising-edge clock; all state changes on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 mr, mw  in  1 each  load/store request from EX/MEM register; never both 1.
REQ-004 br, j, jr  in  1 each  branch / jump / jump-register controls from EX/MEM.
REQ-005 funct3  in  3  access size+sign (loads/stores) or branch condition (br).
REQ-006 alu_result  in  32  effective address (mem ops) or jump-register target (jr).
REQ-007 adder_result  in  32  PC-relative branch/jump target.
REQ-008 rd2  in  32  store data.
REQ-009 zero, neg, carry, overflow  in  1 each  ALU flags; carry=1 means no unsigned borrow (a>=b).
REQ-010 dmem_req  out  1  data-memory request; dmem_we out 1 write; dmem_addr out 32 word address (low 2 bits 0); dmem_wdata out 32; dmem_be out 4 byte enables.
REQ-011 dmem_ack  in  1  memory completion; dmem_rdata in 32 valid when dmem_ack=1.
REQ-012 load_data  out  32  aligned, extended load result (registered).
REQ-013 stall  out  1  freeze upstream stages and EX/MEM register.
REQ-014 pc_src  out  1  redirect fetch; pc_target out 32 redirect address.
REQ-015 misalign  out  1  one-cycle pulse on misaligned access.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE.
REQ-017 IDLE: (mr|mw) and aligned -> dmem_req=1, stall=1, next WAIT; otherwise stall=0, stay IDLE.
REQ-018 WAIT: hold dmem_req/we/addr/wdata/be stable, stall=1; on dmem_ack -> capture load_data, next DONE.
REQ-019 DONE: dmem_req=0, stall=0 (pipeline advances this edge), mr/mw ignored, next IDLE.
REQ-020 Load latency: minimum 3 cycles (issue, ack, done) with dmem_ack in first WAIT cycle.
REQ-021 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; violation -> misalign=1 one cycle, no request, stall=0, store suppressed, load_data unchanged.
REQ-022 Stores: funct3 000 SB be=0001<<addr[1:0], byte replicated x4; 001 SH be=0011 or 1100, halfword replicated x2; 010 SW be=1111.
REQ-023 Loads: 000 LB, 001 LH sign-extend; 100 LBU, 101 LHU zero-extend; 010 LW; lane selected by addr[1:0]; other funct3 -> load_data=0.
REQ-024 Branch condition (br=1): 000 zero; 001 !zero; 100 neg^overflow; 101 !(neg^overflow); 110 !carry; 111 carry; 010/011 never taken.
REQ-025 pc_src combinational = (br&cond)|j|jr, forced 0 while stall=1; pc_target = jr ? {alu_result[31:1],1'b0} : adder_result.
REQ-026 dmem_ack outside WAIT SHALL be ignored.

Reset
REQ-027 reset SHALL force state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, load_data=0, misalign=0, stall=0, timeout counter=0, timeout_err=0.
REQ-028 reset during WAIT SHALL abandon the access with dmem_req=0 next cycle; a later dmem_ack is ignored.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN: when defined, adds output timeout_err (1 bit) and an 8-bit WAIT-cycle counter; 255 WAIT cycles without ack -> timeout_err=1 sticky until reset, load_data=0, next DONE.
REQ-030 Without MEM_TIMEOUT_EN: no port, no counter; WAIT persists indefinitely until dmem_ack.

Verification
REQ-031 LW addr=0x100, ack after 2 WAIT cycles, rdata=0xDEADBEEF -> stall high 3 cycles, load_data=0xDEADBEEF, dmem_be=1111.
REQ-032 LB addr=0x103, rdata=0x80xxxxxx -> load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr=0x202, rd2=0x1234ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1.
REQ-034 SW addr=0x101 -> misalign pulse, dmem_req stays 0, stall 0.
REQ-035 br=1, funct3=100, neg=1, overflow=0, adder_result=0x40 -> pc_src=1, pc_target=0x40; jr=1, alu_result=0x55 -> pc_target=0x54.
REQ-036 MEM_TIMEOUT_EN, no ack -> timeout_err=1 after 255 WAIT cycles, stall drops; reset mid-WAIT -> dmem_req=0 next cycle.
